// File: rtl/reset_sequencer_if.sv
// Reset sequencer interface: key and software reset inputs, staggered reset
// outputs and status.
interface reset_sequencer_if #(
  parameter int unsigned NUM_CH = 3
);
  logic              key_n;
  logic              sw_req;
  logic [NUM_CH-1:0] rst_out;
  logic              ready;
  logic              key_db;
  logic [1:0]        reset_cause;

  modport master (
    output key_n, sw_req,
    input  rst_out, ready, key_db, reset_cause
  );

  modport slave (
    input  key_n, sw_req,
    output rst_out, ready, key_db, reset_cause
  );
endinterface

// File: rtl/reset_sequencer.sv
// Power-on/user reset controller: holds NUM_CH reset domains, releases them in
// ascending order, and re-triggers on a debounced key or a software request.
module reset_sequencer #(
  parameter int unsigned NUM_CH          = 3,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned STAGGER_CYCLES  = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = 16
) (
  input logic              clk50,
  input logic              reset,
  reset_sequencer_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_RUN} state_t;

  logic              sync1, sync2;
  logic              key_db, key_db_q;
  logic [CNT_W-1:0]  db_cnt;
  logic              key_fall, trig;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [NUM_CH-1:0] rst_out, rst_out_n;
  logic              ready, ready_n;
  logic [1:0]        cause, cause_n;

  // Key synchroniser and debounce; key_db flips only after a stable run
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      key_db   <= 1'b1;
      key_db_q <= 1'b1;
      db_cnt   <= '0;
    end else begin
      sync1    <= bus.key_n;
      sync2    <= sync1;
      key_db_q <= key_db;
      if (sync2 != key_db) begin
        if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          key_db <= ~key_db;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign key_fall = key_db_q & ~key_db;
  assign trig     = key_fall | bus.sw_req | ~key_db;

  // Sequencer state register
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state   <= ST_ASSERT;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      cause   <= 2'b00;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      rst_out <= rst_out_n;
      ready   <= ready_n;
      cause   <= cause_n;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    rst_out_n = rst_out;
    ready_n   = ready;
    cause_n   = cause;

    // Only edge events record a cause; a held key does not overwrite it
    if (key_fall | bus.sw_req) cause_n = {bus.sw_req, key_fall};

    case (state)
      ST_ASSERT: begin
        rst_out_n = '1;
        ready_n   = 1'b0;
        if (trig) begin
          cnt_n = '0;
        end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          rst_out_n[0] = 1'b0;
          cnt_n        = '0;
          idx_n        = IDX_W'(1);
          if (NUM_CH == 1) begin
            state_n = ST_RUN;
            ready_n = 1'b1;
          end else begin
            state_n = ST_RELEASE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (trig) begin
          state_n   = ST_ASSERT;
          rst_out_n = '1;
          ready_n   = 1'b0;
          cnt_n     = '0;
          idx_n     = '0;
        end else if (cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(i)) rst_out_n[i] = 1'b0;
          end
          cnt_n = '0;
          if (idx == IDX_W'(NUM_CH - 1)) begin
            state_n = ST_RUN;
            ready_n = 1'b1;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (trig) begin
          state_n   = ST_ASSERT;
          rst_out_n = '1;
          ready_n   = 1'b0;
          cnt_n     = '0;
          idx_n     = '0;
        end
      end
      default: begin
        state_n   = ST_ASSERT;
        rst_out_n = '1;
        ready_n   = 1'b0;
        cnt_n     = '0;
        idx_n     = '0;
      end
    endcase
  end

  assign bus.rst_out     = rst_out;
  assign bus.ready       = ready;
  assign bus.key_db      = key_db;
  assign bus.reset_cause = cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a 3-channel and a 1-channel instance.
module tb_reset_sequencer;

  logic clk50 = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  reset_sequencer_if #(.NUM_CH(3)) bus3 ();
  reset_sequencer_if #(.NUM_CH(1)) bus1 ();

  reset_sequencer #(
    .NUM_CH(3), .HOLD_CYCLES(4), .STAGGER_CYCLES(2),
    .DEBOUNCE_CYCLES(8), .CNT_W(8)
  ) dut3 (.clk50(clk50), .reset(reset), .bus(bus3.slave));

  reset_sequencer #(
    .NUM_CH(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1),
    .DEBOUNCE_CYCLES(8), .CNT_W(8)
  ) dut1 (.clk50(clk50), .reset(reset), .bus(bus1.slave));

  always #5 clk50 = ~clk50;

  task automatic step(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus3.key_n  = 1'b1;
    bus3.sw_req = 1'b0;
    bus1.key_n  = 1'b1;
    bus1.sw_req = 1'b0;
    #23;
    chk("rst_rst_out",  32'(bus3.rst_out), 32'h7);
    chk("rst_ready",    32'(bus3.ready), 32'h0);
    chk("rst_key_db",   32'(bus3.key_db), 32'h1);
    chk("rst_cause",    32'(bus3.reset_cause), 32'h0);
    chk("rst1_rst_out", 32'(bus1.rst_out), 32'h1);

    // Power-on sequence
    reset = 1'b0;
    step(1);
    chk("ch1_rst_out_e1", 32'(bus1.rst_out), 32'h0);
    chk("ch1_ready_e1",   32'(bus1.ready), 32'h1);
    chk("po_e1",          32'(bus3.rst_out), 32'h7);
    step(2);
    chk("po_e3",          32'(bus3.rst_out), 32'h7);
    step(1);
    chk("po_e4",          32'(bus3.rst_out), 32'h6);
    step(1);
    chk("po_e5",          32'(bus3.rst_out), 32'h6);
    step(1);
    chk("po_e6",          32'(bus3.rst_out), 32'h4);
    step(1);
    chk("po_e7_ready",    32'(bus3.ready), 32'h0);
    step(1);
    chk("po_e8_rst_out",  32'(bus3.rst_out), 32'h0);
    chk("po_e8_ready",    32'(bus3.ready), 32'h1);
    chk("po_cause",       32'(bus3.reset_cause), 32'h0);

    // Software request from RUN
    bus3.sw_req = 1'b1;
    step(1);
    bus3.sw_req = 1'b0;
    chk("sw_rst_out", 32'(bus3.rst_out), 32'h7);
    chk("sw_ready",   32'(bus3.ready), 32'h0);
    chk("sw_cause",   32'(bus3.reset_cause), 32'h2);
    step(7);
    chk("sw_e7_ready", 32'(bus3.ready), 32'h0);
    step(1);
    chk("sw_e8_ready", 32'(bus3.ready), 32'h1);
    chk("sw_e8_rst",   32'(bus3.rst_out), 32'h0);

    // Short glitch is filtered
    bus3.key_n = 1'b0;
    step(5);
    bus3.key_n = 1'b1;
    step(12);
    chk("glitch_key_db", 32'(bus3.key_db), 32'h1);
    chk("glitch_ready",  32'(bus3.ready), 32'h1);
    chk("glitch_rst",    32'(bus3.rst_out), 32'h0);

    // Long press holds the system in reset
    bus3.key_n = 1'b0;
    step(9);
    chk("kp_e9_key_db",  32'(bus3.key_db), 32'h1);
    step(1);
    chk("kp_e10_key_db", 32'(bus3.key_db), 32'h0);
    chk("kp_e10_ready",  32'(bus3.ready), 32'h1);
    step(1);
    chk("kp_e11_rst",    32'(bus3.rst_out), 32'h7);
    chk("kp_e11_ready",  32'(bus3.ready), 32'h0);
    chk("kp_cause",      32'(bus3.reset_cause), 32'h1);
    step(9);
    chk("kp_held_rst",   32'(bus3.rst_out), 32'h7);
    bus3.key_n = 1'b1;
    step(9);
    chk("kr_e9_key_db",  32'(bus3.key_db), 32'h0);
    step(1);
    chk("kr_e10_key_db", 32'(bus3.key_db), 32'h1);
    chk("kr_e10_rst",    32'(bus3.rst_out), 32'h7);
    step(7);
    chk("kr_e17_rst",    32'(bus3.rst_out), 32'h4);
    chk("kr_e17_ready",  32'(bus3.ready), 32'h0);
    step(1);
    chk("kr_e18_ready",  32'(bus3.ready), 32'h1);
    chk("kr_cause",      32'(bus3.reset_cause), 32'h1);

    // Key fall and software request on the same edge
    bus3.key_n = 1'b0;
    step(10);
    chk("both_key_db", 32'(bus3.key_db), 32'h0);
    bus3.sw_req = 1'b1;
    step(1);
    bus3.sw_req = 1'b0;
    chk("both_cause", 32'(bus3.reset_cause), 32'h3);
    chk("both_rst",   32'(bus3.rst_out), 32'h7);
    bus3.key_n = 1'b1;
    step(10);
    chk("both_key_up", 32'(bus3.key_db), 32'h1);
    step(7);
    chk("both_e7_ready", 32'(bus3.ready), 32'h0);
    step(1);
    chk("both_e8_ready", 32'(bus3.ready), 32'h1);
    chk("both_e8_cause", 32'(bus3.reset_cause), 32'h3);

    // Asynchronous reset mid-release
    bus3.sw_req = 1'b1;
    step(1);
    bus3.sw_req = 1'b0;
    step(6);
    chk("ar_pre_rst", 32'(bus3.rst_out), 32'h4);
    reset = 1'b1;
    #1;
    chk("ar_rst",   32'(bus3.rst_out), 32'h7);
    chk("ar_ready", 32'(bus3.ready), 32'h0);
    chk("ar_cause", 32'(bus3.reset_cause), 32'h0);
    reset = 1'b0;
    step(7);
    chk("ar_e7_ready", 32'(bus3.ready), 32'h0);
    step(1);
    chk("ar_e8_ready", 32'(bus3.ready), 32'h1);
    chk("ar_e8_rst",   32'(bus3.rst_out), 32'h0);

    // Software request during ASSERT restarts the hold
    bus3.sw_req = 1'b1;
    step(1);
    bus3.sw_req = 1'b0;
    step(2);
    bus3.sw_req = 1'b1;
    step(1);
    bus3.sw_req = 1'b0;
    chk("sa_cause", 32'(bus3.reset_cause), 32'h2);
    step(3);
    chk("sa_e3_rst", 32'(bus3.rst_out), 32'h7);
    step(1);
    chk("sa_e4_rst", 32'(bus3.rst_out), 32'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
